// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one 32-bit add/sub unit between NUM_REQ requesters.
// Optional macro ADDSUB_ARB_OVF_EN adds a registered signed-overflow flag (rsp_ovf_o).
module addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_a_i,
  input  logic [NUM_REQ*32-1:0]   req_b_i,
  input  logic [NUM_REQ-1:0]      req_mode_i,
  output logic [31:0]             a_o,
  output logic [31:0]             b_o,
  output logic                    mode_o,
  input  logic [31:0]             sum_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [31:0]             rsp_sum_o
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic                    rsp_ovf_o
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [31:0]     a_q, b_q, rsp_sum_q;
  logic            mode_q, rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;

  logic [ID_W-1:0] grant, scan;
  logic            grant_vld;
  logic [31:0]     sel_a, sel_b;
  logic            sel_mode;

  // Search for the first valid requester starting at the priority pointer, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && req_valid_i[scan]) begin
        grant_vld = 1'b1;
        grant     = scan;
      end
      scan = (scan == ID_W'(NUM_REQ - 1)) ? '0 : scan + ID_W'(1);
    end
  end

  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    sel_mode    = 1'b0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a    = req_a_i[i*32 +: 32];
        sel_b    = req_b_i[i*32 +: 32];
        sel_mode = req_mode_i[i];
        req_ready_o[i] = rst_n_i && (state_q == IDLE) && grant_vld;
      end
    end
  end

  assign ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);

`ifdef ADDSUB_ARB_OVF_EN
  logic rsp_ovf_q, ovf_d;

  // Subtraction overflows only when the operand signs differ; addition only when they match.
  always_comb begin
    ovf_d = 1'b0;
    if (mode_q) ovf_d = (a_q[31] != b_q[31]) && (sum_i[31] != a_q[31]);
    else        ovf_d = (a_q[31] == b_q[31]) && (sum_i[31] != a_q[31]);
  end

  assign rsp_ovf_o = rsp_ovf_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            mode_q   <= sel_mode;
            rsp_id_q <= grant;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= sum_i;
          rsp_valid_q <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
          rsp_ovf_q   <= ovf_d;
`endif
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign mode_o      = mode_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;

endmodule
